buyruk_bellegi_hakem: RTL and testbench
=======================================

# buyruk_bellegi_hakem

Arbiter and sequencer for the instruction-memory SRAM macro (port 0: 1RW, port 1: 1R) that sits outside the c0 macro. It shares the SRAM between the core fetch unit (read-only) and the host loader (read/write). It holds fetch off during the post-reset load phase and resolves port-1 read contention round-robin. It also tracks which requester owns the one-cycle-latency read data.

## Interface
Parameters:
- ADRES_BIT, default `BB_ADRES_BIT: word-address width.

Ports:
- clk_i  in  1  the single clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- getir_istek_i  in  1  fetch read request.
- getir_adres_i  in  ADRES_BIT  fetch word address.
- getir_kabul_o  out  1  fetch request granted this cycle (combinational).
- getir_veri_o  out  32  fetch read data.
- getir_gecerli_o  out  1  getir_veri_o valid (one-cycle pulse).
- yuk_istek_i  in  1  host request.
- yuk_yaz_i  in  1  1 = write, 0 = read.
- yuk_maske_i  in  4  byte write mask.
- yuk_adres_i  in  ADRES_BIT  host word address.
- yuk_veri_i  in  32  host write data.
- yuk_kabul_o  out  1  host request granted (combinational).
- yuk_veri_o  out  32  host read data.
- yuk_gecerli_o  out  1  yuk_veri_o valid (pulse).
- yuk_bitti_i  in  1  load-complete pulse; moves the block from BOOT to RUN.
- calisiyor_o  out  1  state == RUN.
- csb0, web0  out  1 each  port-0 chip select / write enable, active-low.
- wmask0  out  4  port-0 write mask.
- addr0  out  ADRES_BIT  port-0 address.
- din0  out  32  port-0 write data.
- dout0  in  32  port-0 read data; unused.
- csb1  out  1  port-1 chip select, active-low.
- addr1  out  ADRES_BIT  port-1 address.
- dout1  in  32  port-1 read data.

## Operation
- States: BOOT (reset state), RUN.
  - BOOT→RUN on the first clock edge where yuk_bitti_i=1.
  - RUN is left only by reset.
- BOOT:
  - Only the host is served; getir_kabul_o=0.
- Host write (yuk_istek_i & yuk_yaz_i):
  - Always granted. Drives port 0: csb0=0, web0=0, wmask0=yuk_maske_i, addr0/din0 from the host.
  - A write with yuk_maske_i=0 is granted but leaves csb0=1.
- Port 1 reads, from fetch and host:
  - Only one requester is granted per cycle.
  - Uncontested: the sole requester is granted.
  - Contested: a 1-bit round-robin pointer picks the winner. The pointer then points at the loser. The pointer changes only on contested cycles; its reset value favours fetch.
- Read/write collision:
  - If a fetch read targets the same address as a granted host write in the same cycle, the fetch is not granted. It must hold its request; it is served in a later cycle.
- Read data ownership:
  - A registered owner tag (NONE/GETIR/YUK) is set on each port-1 grant.
  - In the next cycle, dout1 is routed to the owner's veri output and that owner's gecerli pulses.
  - Each veri output holds its last captured value until that requester's next read completes.
- Grants may occur every cycle (back-to-back reads from the same requester allowed).
- Idle outputs:
  - csb0=1, web0=1, wmask0=0, csb1=1.
  - addr0, addr1 and din0 are driven from the host/fetch inputs; don't-care while csb is high.

## Timing
- Grant is combinational in the request cycle. SRAM signals are asserted in the same cycle and sampled by the macro at the clock edge.
- Read latency: request/grant in cycle N, gecerli=1 with data in cycle N+1.
- Write: complete at the clock edge that ends the grant cycle. A read of the same address granted in the next cycle returns the new data.
- yuk_bitti_i in cycle N: fetch can first be granted in cycle N+1. A host read granted in cycle N still returns in N+1.
- Reset (asynchronous assertion, any time):
  - Combinational outputs: csb0=1, csb1=1, web0=1, kabul=0.
  - Registers: gecerli=0, veri=0, owner=NONE, pointer=fetch, state=BOOT, calisiyor_o=0.
  - Read data pending when reset asserts is discarded.

## Configuration
- `BB_YAZMA_KILIDI_EN` defined:
  - In RUN, host writes are still granted (yuk_kabul_o=1) but port 0 stays idle (csb0=1).
  - A registered yuk_hata_o output pulses the next cycle.
  - BOOT writes are unaffected.
- Not defined: host writes are served in both states and yuk_hata_o does not exist.

## Structure
- State and owner-tag encodings go in sabitler.vh next to `BB_ADRES_BIT (`BB_HAKEM_BOOT/RUN, `BB_SAHIP_YOK/GETIR/YUK).
- One natural sub-module: buyruk_bellegi_rr_hakem, the 2-way round-robin grant with its pointer register.

## Test plan
- Reset, then fetch request at 0x10 in BOOT → getir_kabul_o=0 and csb1=1. Host write 0xDEADBEEF to 0x10 with mask 4'hF → csb0=0, web0=0, wmask0=4'hF.
- yuk_bitti_i pulse, then fetch 0x10 → kabul in the request cycle; getir_gecerli_o and getir_veri_o=0xDEADBEEF in the next cycle. calisiyor_o=1.
- Fetch and host read both request every cycle for 4 cycles → grants alternate GETIR, YUK, GETIR, YUK; each gecerli lands on the correct port one cycle after its grant.
- Host write to 0x20 while fetch reads 0x20 → fetch denied that cycle; its retry next cycle returns the new data. With fetch at 0x24 instead, both are granted.
- rst_ni asserted in the cycle after a fetch grant → no getir_gecerli_o pulse, state=BOOT, all csb high immediately.
- With `BB_YAZMA_KILIDI_EN`: RUN-state host write → yuk_kabul_o=1, csb0=1, yuk_hata_o pulses one cycle later, memory unchanged on readback.

Source files
------------

// File: rtl/buyruk_bellegi_hakem_pkg.sv
// Shared constants and types for the instruction-memory arbiter.
// This file plays the role of sabitler.vh: it holds the default address width
// and the state / owner-tag encodings, and must be compiled before the other
// rtl/ files.
// Optional feature macro: BB_YAZMA_KILIDI_EN (host write lock in RUN).
`ifndef BB_SABITLER_TANIMLI
`define BB_SABITLER_TANIMLI
`ifndef BB_ADRES_BIT
`define BB_ADRES_BIT 8
`endif
`define BB_HAKEM_BOOT 1'b0
`define BB_HAKEM_RUN  1'b1
`define BB_SAHIP_YOK   2'd0
`define BB_SAHIP_GETIR 2'd1
`define BB_SAHIP_YUK   2'd2
`endif

package buyruk_bellegi_hakem_pkg;

    typedef enum logic {
        HAKEM_BOOT = `BB_HAKEM_BOOT,
        HAKEM_RUN  = `BB_HAKEM_RUN
    } hakem_durum_e;

    typedef enum logic [1:0] {
        SAHIP_YOK   = `BB_SAHIP_YOK,
        SAHIP_GETIR = `BB_SAHIP_GETIR,
        SAHIP_YUK   = `BB_SAHIP_YUK
    } sahip_e;

endpackage

// File: rtl/buyruk_bellegi_hakem_rr_hakem.sv
// Two-way round-robin grant for the port-1 read requesters (fetch, host).
// The pointer only moves on contested cycles and then points at the loser.
module buyruk_bellegi_rr_hakem (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic istek_getir_i,
    input  logic istek_yuk_i,
    output logic kabul_getir_o,
    output logic kabul_yuk_o
);

    // 0 favours fetch, 1 favours host
    logic isaret_q, isaret_d;
    logic cekisme;

    // Grant selection and pointer update
    always_comb begin
        cekisme       = istek_getir_i & istek_yuk_i;
        kabul_getir_o = istek_getir_i & (~istek_yuk_i | ~isaret_q);
        kabul_yuk_o   = istek_yuk_i & (~istek_getir_i | isaret_q);
        isaret_d      = isaret_q;
        if (cekisme) begin
            isaret_d = ~isaret_q;
        end
    end

    // Pointer register, reset favours fetch
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            isaret_q <= 1'b0;
        end else begin
            isaret_q <= isaret_d;
        end
    end

endmodule

// File: rtl/buyruk_bellegi_hakem.sv
// Arbiter/sequencer sharing the instruction SRAM (port 0 1RW, port 1 1R)
// between the core fetch unit and the host loader. Fetch is held off in BOOT;
// port-1 contention is round-robin; a registered owner tag routes the
// one-cycle-latency read data.
// Optional feature macro: BB_YAZMA_KILIDI_EN (host writes ignored in RUN,
// reported on yuk_hata_o).
module buyruk_bellegi_hakem
    import buyruk_bellegi_hakem_pkg::*;
#(
    parameter int ADRES_BIT = `BB_ADRES_BIT
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 getir_istek_i,
    input  logic [ADRES_BIT-1:0] getir_adres_i,
    output logic                 getir_kabul_o,
    output logic [31:0]          getir_veri_o,
    output logic                 getir_gecerli_o,
    input  logic                 yuk_istek_i,
    input  logic                 yuk_yaz_i,
    input  logic [3:0]           yuk_maske_i,
    input  logic [ADRES_BIT-1:0] yuk_adres_i,
    input  logic [31:0]          yuk_veri_i,
    output logic                 yuk_kabul_o,
    output logic [31:0]          yuk_veri_o,
    output logic                 yuk_gecerli_o,
`ifdef BB_YAZMA_KILIDI_EN
    output logic                 yuk_hata_o,
`endif
    input  logic                 yuk_bitti_i,
    output logic                 calisiyor_o,
    output logic                 csb0,
    output logic                 web0,
    output logic [3:0]           wmask0,
    output logic [ADRES_BIT-1:0] addr0,
    output logic [31:0]          din0,
    input  logic [31:0]          dout0,
    output logic                 csb1,
    output logic [ADRES_BIT-1:0] addr1,
    input  logic [31:0]          dout1
);

    hakem_durum_e durum_q, durum_d;
    sahip_e       sahip_q, sahip_d;
    logic [31:0]  getir_veri_q, yuk_veri_q;

    logic calisma;
    logic yaz_istek, yaz_kilitli, yaz_etkin, carpisma;
    logic getir_oku, yuk_oku;
    logic kabul_getir, kabul_yuk_oku;
    logic unused_dout0;

    assign unused_dout0 = ^dout0;
    assign calisma      = (durum_q == HAKEM_RUN);

    // Write path, collision detection and read requests; all gated by reset
    always_comb begin
        yaz_istek   = rst_ni & yuk_istek_i & yuk_yaz_i;
`ifdef BB_YAZMA_KILIDI_EN
        yaz_kilitli = calisma;
`else
        yaz_kilitli = 1'b0;
`endif
        yaz_etkin   = yaz_istek & (|yuk_maske_i) & ~yaz_kilitli;
        carpisma    = yaz_etkin & (getir_adres_i == yuk_adres_i);
        getir_oku   = rst_ni & calisma & getir_istek_i & ~carpisma;
        yuk_oku     = rst_ni & yuk_istek_i & ~yuk_yaz_i;
    end

    buyruk_bellegi_rr_hakem u_rr (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .istek_getir_i (getir_oku),
        .istek_yuk_i   (yuk_oku),
        .kabul_getir_o (kabul_getir),
        .kabul_yuk_o   (kabul_yuk_oku)
    );

    // Grants, SRAM port drive, next state and next owner
    always_comb begin
        getir_kabul_o = kabul_getir;
        yuk_kabul_o   = yaz_istek | kabul_yuk_oku;
        csb0          = ~yaz_etkin;
        web0          = ~yaz_etkin;
        wmask0        = yaz_etkin ? yuk_maske_i : 4'h0;
        addr0         = yuk_adres_i;
        din0          = yuk_veri_i;
        csb1          = ~(kabul_getir | kabul_yuk_oku);
        addr1         = kabul_yuk_oku ? yuk_adres_i : getir_adres_i;
        durum_d       = durum_q;
        if (durum_q == HAKEM_BOOT && yuk_bitti_i) begin
            durum_d = HAKEM_RUN;
        end
        sahip_d = SAHIP_YOK;
        if (kabul_getir) begin
            sahip_d = SAHIP_GETIR;
        end else if (kabul_yuk_oku) begin
            sahip_d = SAHIP_YUK;
        end
    end

    // Read data routing: the owner sees dout1 live, the other holds its last value
    always_comb begin
        getir_gecerli_o = (sahip_q == SAHIP_GETIR);
        yuk_gecerli_o   = (sahip_q == SAHIP_YUK);
        getir_veri_o    = getir_gecerli_o ? dout1 : getir_veri_q;
        yuk_veri_o      = yuk_gecerli_o ? dout1 : yuk_veri_q;
        calisiyor_o     = calisma;
    end

    // State, owner tag and captured read data
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            durum_q      <= HAKEM_BOOT;
            sahip_q      <= SAHIP_YOK;
            getir_veri_q <= 32'h0;
            yuk_veri_q   <= 32'h0;
        end else begin
            durum_q <= durum_d;
            sahip_q <= sahip_d;
            if (sahip_q == SAHIP_GETIR) begin
                getir_veri_q <= dout1;
            end
            if (sahip_q == SAHIP_YUK) begin
                yuk_veri_q <= dout1;
            end
        end
    end

`ifdef BB_YAZMA_KILIDI_EN
    logic hata_q;

    // Flags a host write dropped by the RUN-state lock
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hata_q <= 1'b0;
        end else begin
            hata_q <= yaz_istek & yaz_kilitli;
        end
    end

    assign yuk_hata_o = hata_q;
`endif

endmodule

// File: tb/tb_buyruk_bellegi_hakem.sv
// Scoreboard bench for buyruk_bellegi_hakem with a behavioural SRAM model.
module tb_buyruk_bellegi_hakem;

    localparam int AW = 8;
`ifdef BB_YAZMA_KILIDI_EN
    localparam bit KILIT = 1'b1;
`else
    localparam bit KILIT = 1'b0;
`endif
    localparam logic [1:0] S_YOK = 2'd0, S_GETIR = 2'd1, S_YUK = 2'd2;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          getir_istek = 1'b0;
    logic [AW-1:0] getir_adres = '0;
    logic          getir_kabul;
    logic [31:0]   getir_veri;
    logic          getir_gecerli;
    logic          yuk_istek = 1'b0;
    logic          yuk_yaz = 1'b0;
    logic [3:0]    yuk_maske = 4'h0;
    logic [AW-1:0] yuk_adres = '0;
    logic [31:0]   yuk_veri = 32'h0;
    logic          yuk_kabul;
    logic [31:0]   yuk_veri_o;
    logic          yuk_gecerli;
    logic          yuk_hata;
    logic          yuk_bitti = 1'b0;
    logic          calisiyor;
    logic          csb0, web0, csb1;
    logic [3:0]    wmask0;
    logic [AW-1:0] addr0, addr1;
    logic [31:0]   din0, dout0, dout1;

    logic [31:0] sram [0:(1<<AW)-1];
    logic [31:0] ref_mem [0:(1<<AW)-1];

    typedef struct {
        logic [1:0]  sahip;
        logic [31:0] veri;
    } bek_t;
    bek_t kuyruk[$];

    int kontrol_sayisi = 0;
    int hata_sayisi = 0;
    logic        tb_run = 1'b0;
    logic [31:0] son_getir = 32'h0;
    logic [31:0] son_yuk = 32'h0;

    always #5 clk = ~clk;

    assign dout0 = 32'h0;

    buyruk_bellegi_hakem #(.ADRES_BIT(AW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .getir_istek_i  (getir_istek),
        .getir_adres_i  (getir_adres),
        .getir_kabul_o  (getir_kabul),
        .getir_veri_o   (getir_veri),
        .getir_gecerli_o(getir_gecerli),
        .yuk_istek_i    (yuk_istek),
        .yuk_yaz_i      (yuk_yaz),
        .yuk_maske_i    (yuk_maske),
        .yuk_adres_i    (yuk_adres),
        .yuk_veri_i     (yuk_veri),
        .yuk_kabul_o    (yuk_kabul),
        .yuk_veri_o     (yuk_veri_o),
        .yuk_gecerli_o  (yuk_gecerli),
`ifdef BB_YAZMA_KILIDI_EN
        .yuk_hata_o     (yuk_hata),
`endif
        .yuk_bitti_i    (yuk_bitti),
        .calisiyor_o    (calisiyor),
        .csb0           (csb0),
        .web0           (web0),
        .wmask0         (wmask0),
        .addr0          (addr0),
        .din0           (din0),
        .dout0          (dout0),
        .csb1           (csb1),
        .addr1          (addr1),
        .dout1          (dout1)
    );

`ifndef BB_YAZMA_KILIDI_EN
    assign yuk_hata = 1'b0;
`endif

    // SRAM macro model: port 0 masked write, port 1 registered read
    always @(posedge clk) begin
        if (!csb0 && !web0) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask0[b]) sram[addr0][8*b +: 8] <= din0[8*b +: 8];
            end
        end
        if (!csb1) dout1 <= sram[addr1];
    end

    task automatic kontrol(input string etiket, input logic [31:0] gozlenen,
                           input logic [31:0] beklenen);
        kontrol_sayisi++;
        if (gozlenen !== beklenen) begin
            hata_sayisi++;
            $display("FAIL %s: got=%08h expected=%08h", etiket, gozlenen, beklenen);
        end
    endtask

    task automatic sur(input logic gi, input logic [AW-1:0] ga, input logic yi,
                       input logic yy, input logic [3:0] ym, input logic [AW-1:0] ya,
                       input logic [31:0] yv, input logic bt);
        getir_istek = gi; getir_adres = ga;
        yuk_istek = yi; yuk_yaz = yy; yuk_maske = ym;
        yuk_adres = ya; yuk_veri = yv; yuk_bitti = bt;
    endtask

    // One clock cycle: check grants/SRAM drive, push expectation, then check returned data
    task automatic adim(input logic e_gk, input logic e_yo, input string tag);
        logic yaz_g, etkin, hata_bek;
        bek_t e;
        #1;
        yaz_g = yuk_istek && yuk_yaz;
        etkin = yaz_g && (yuk_maske != 4'h0) && !(KILIT && tb_run);
        hata_bek = yaz_g && KILIT && tb_run;
        kontrol({tag, "/getir_kabul"}, {31'b0, getir_kabul}, {31'b0, e_gk});
        kontrol({tag, "/yuk_kabul"}, {31'b0, yuk_kabul}, {31'b0, yaz_g | e_yo});
        kontrol({tag, "/csb0"}, {31'b0, csb0}, {31'b0, !etkin});
        kontrol({tag, "/csb1"}, {31'b0, csb1}, {31'b0, !(e_gk | e_yo)});
        if (etkin) begin
            kontrol({tag, "/web0"}, {31'b0, web0}, 32'h0);
            kontrol({tag, "/wmask0"}, {28'b0, wmask0}, {28'b0, yuk_maske});
            kontrol({tag, "/addr0"}, {24'b0, addr0}, {24'b0, yuk_adres});
            kontrol({tag, "/din0"}, din0, yuk_veri);
        end
        if (e_gk) begin
            e.sahip = S_GETIR; e.veri = ref_mem[getir_adres];
        end else if (e_yo) begin
            e.sahip = S_YUK; e.veri = ref_mem[yuk_adres];
        end else begin
            e.sahip = S_YOK; e.veri = 32'h0;
        end
        kuyruk.push_back(e);
        if (etkin) begin
            for (int b = 0; b < 4; b++) begin
                if (yuk_maske[b]) ref_mem[yuk_adres][8*b +: 8] = yuk_veri[8*b +: 8];
            end
        end
        @(posedge clk);
        if (yuk_bitti) tb_run = 1'b1;
        #1;
        kontrol({tag, "/calisiyor"}, {31'b0, calisiyor}, {31'b0, tb_run});
        if (KILIT) kontrol({tag, "/yuk_hata"}, {31'b0, yuk_hata}, {31'b0, hata_bek});
        if (kuyruk.size() == 0) begin
            kontrol({tag, "/kuyruk"}, 32'h0, 32'h1);
        end else begin
            e = kuyruk.pop_front();
            kontrol({tag, "/getir_gecerli"}, {31'b0, getir_gecerli}, {31'b0, e.sahip == S_GETIR});
            kontrol({tag, "/yuk_gecerli"}, {31'b0, yuk_gecerli}, {31'b0, e.sahip == S_YUK});
            if (e.sahip == S_GETIR) son_getir = e.veri;
            if (e.sahip == S_YUK) son_yuk = e.veri;
            kontrol({tag, "/getir_veri"}, getir_veri, son_getir);
            kontrol({tag, "/yuk_veri"}, yuk_veri_o, son_yuk);
        end
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            sram[i] = 32'hA5000000 ^ (i * 32'h00010203);
            ref_mem[i] = 32'hA5000000 ^ (i * 32'h00010203);
        end
        sur(1'b1, 8'h10, 1'b1, 1'b1, 4'hF, 8'h10, 32'h1, 1'b0);
        #12;
        kontrol("reset/getir_kabul", {31'b0, getir_kabul}, 32'h0);
        kontrol("reset/yuk_kabul", {31'b0, yuk_kabul}, 32'h0);
        kontrol("reset/csb0", {31'b0, csb0}, 32'h1);
        kontrol("reset/csb1", {31'b0, csb1}, 32'h1);
        kontrol("reset/web0", {31'b0, web0}, 32'h1);
        kontrol("reset/calisiyor", {31'b0, calisiyor}, 32'h0);
        kontrol("reset/getir_gecerli", {31'b0, getir_gecerli}, 32'h0);
        kontrol("reset/getir_veri", getir_veri, 32'h0);
        @(negedge clk);
        rst_ni = 1'b1;

        sur(1'b1, 8'h10, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
        adim(1'b0, 1'b0, "boot_getir");
        sur(1'b0, 8'h10, 1'b1, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 1'b0);
        adim(1'b0, 1'b0, "boot_yaz");
        sur(1'b0, 8'h10, 1'b1, 1'b0, 4'h0, 8'h10, 32'h0, 1'b0);
        adim(1'b0, 1'b1, "boot_oku");
        sur(1'b1, 8'h10, 1'b1, 1'b0, 4'h0, 8'h11, 32'h0, 1'b1);
        adim(1'b0, 1'b1, "bitti");
        sur(1'b1, 8'h10, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
        adim(1'b1, 1'b0, "run_getir");

        for (int i = 0; i < 4; i++) begin
            sur(1'b1, 8'(8'h30 + i), 1'b1, 1'b0, 4'h0, 8'(8'h40 + i), 32'h0, 1'b0);
            adim(i % 2 == 0, i % 2 == 1, "cekisme");
        end

        sur(1'b1, 8'h20, 1'b1, 1'b1, 4'hF, 8'h20, 32'hCAFEF00D, 1'b0);
        adim(KILIT, 1'b0, "carpisma");
        sur(1'b1, 8'h20, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
        adim(1'b1, 1'b0, "carpisma_tekrar");

        sur(1'b1, 8'h24, 1'b1, 1'b1, 4'hF, 8'h20, 32'h11111111, 1'b0);
        adim(1'b1, 1'b0, "farkli_adres");
        sur(1'b1, 8'h20, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
        adim(1'b1, 1'b0, "farkli_adres_oku");

        sur(1'b0, 8'h00, 1'b1, 1'b1, 4'h0, 8'h24, 32'h0, 1'b0);
        adim(1'b0, 1'b0, "maske_sifir");
        sur(1'b0, 8'h00, 1'b1, 1'b0, 4'h0, 8'h24, 32'h0, 1'b0);
        adim(1'b0, 1'b1, "maske_sifir_oku");

        sur(1'b0, 8'h00, 1'b1, 1'b1, 4'b0101, 8'h30, 32'h12345678, 1'b0);
        adim(1'b0, 1'b0, "kismi_maske");
        sur(1'b1, 8'h30, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
        adim(1'b1, 1'b0, "kismi_oku");
        sur(1'b1, 8'h31, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
        adim(1'b1, 1'b0, "arka_arkaya");

        // Reset asserted in the cycle after a fetch grant
        sur(1'b1, 8'h10, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
        #1;
        kontrol("rst_oncesi/getir_kabul", {31'b0, getir_kabul}, 32'h1);
        @(posedge clk);
        rst_ni = 1'b0;
        sur(1'b1, 8'h10, 1'b1, 1'b1, 4'hF, 8'h50, 32'h0, 1'b0);
        #1;
        kontrol("rst/getir_gecerli", {31'b0, getir_gecerli}, 32'h0);
        kontrol("rst/getir_kabul", {31'b0, getir_kabul}, 32'h0);
        kontrol("rst/csb0", {31'b0, csb0}, 32'h1);
        kontrol("rst/csb1", {31'b0, csb1}, 32'h1);
        kontrol("rst/calisiyor", {31'b0, calisiyor}, 32'h0);
        kontrol("rst/getir_veri", getir_veri, 32'h0);
        kontrol("rst/yuk_veri", yuk_veri_o, 32'h0);
        kuyruk.delete();
        tb_run = 1'b0;
        son_getir = 32'h0;
        son_yuk = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        sur(1'b1, 8'h10, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0, 1'b0);
        adim(1'b0, 1'b0, "rst_sonrasi_boot");

        $display("TB_RESULT checks=%0d failures=%0d", kontrol_sayisi, hata_sayisi);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
